// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-way resource; holds one-hot grant and 4:1 mux select
// until done, owner withdrawal or timeout, with back-to-back handover between owners.
module mux4_rr_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_busy;
  logic       r_timeout;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;

  state_t     w_state_nx;
  logic [3:0] w_gnt_nx;
  logic [1:0] w_sel_nx;
  logic [1:0] w_ptr_nx;
  logic [7:0] w_cnt_nx;
  logic       w_to_nx;
  logic [3:0] w_owner_oh;
  logic [3:0] w_masked;
  logic [2:0] w_pick;
  logic       w_rel_done;
  logic       w_rel_wd;
  logic       w_rel_to;
  logic       w_release;

  // Returns {found, index}: first set bit of r scanning from p upward, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_owner_oh = 4'b0001 << r_sel;
  assign w_rel_done = done;
  assign w_rel_wd   = ~req[r_sel];
  assign w_rel_to   = (TIMEOUT != 8'd0) && (r_cnt == (TIMEOUT - 8'd1));
  assign w_release  = w_rel_done | w_rel_wd | w_rel_to;
  // The current owner is never a candidate when it releases, so its own req cannot re-win.
  assign w_masked   = (r_state == S_GRANT) ? (req & ~w_owner_oh) : req;
  assign w_pick     = rr_pick(w_masked, r_ptr);

  // Next-state, grant/select and counter logic.
  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    w_to_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick[2]) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = 4'b0001 << w_pick[1:0];
          w_sel_nx   = w_pick[1:0];
          w_ptr_nx   = w_pick[1:0] + 2'd1;
          w_cnt_nx   = 8'd0;
        end else begin
          w_gnt_nx   = 4'b0000;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_to_nx = ~w_rel_done & ~w_rel_wd & w_rel_to;
          if (w_pick[2]) begin
            w_gnt_nx = 4'b0001 << w_pick[1:0];
            w_sel_nx = w_pick[1:0];
            w_ptr_nx = w_pick[1:0] + 2'd1;
            w_cnt_nx = 8'd0;
          end else begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = 4'b0000;
          end
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nx = r_cnt + 8'd1;
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = 4'b0000;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 2'd0;
      r_cnt     <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_sel     <= w_sel_nx;
      r_busy    <= (w_state_nx == S_GRANT);
      r_timeout <= w_to_nx;
      r_ptr     <= w_ptr_nx;
      r_cnt     <= w_cnt_nx;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a cycle model pushes expected outputs per driven cycle,
// popped and compared after the clock edge, plus directed checks of the key scenarios.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  // reference model state
  logic       m_busy = 1'b0;
  logic [3:0] m_gnt  = 4'b0000;
  logic [1:0] m_sel  = 2'd0;
  logic [1:0] m_ptr  = 2'd0;
  int         m_cnt  = 0;
  logic       m_to   = 1'b0;
  localparam int TMO = 16;

  mux4_rr_arbiter #(.TIMEOUT(8'd16)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] rq, input logic dn);
    int win;
    logic [3:0] cand;
    int o;
    logic rel;
    m_to = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_gnt = 4'b0000; m_sel = 2'd0; m_ptr = 2'd0; m_cnt = 0;
    end else begin
      cand = rq;
      rel  = 1'b1;
      if (m_busy) begin
        o = int'(m_sel);
        cand[o] = 1'b0;
        rel = dn || !rq[o] || (m_cnt == TMO - 1);
        if (rel && !dn && rq[o]) m_to = 1'b1;
      end
      if (!rel) begin
        if (m_cnt < 255) m_cnt++;
      end else begin
        win = -1;
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && cand[(int'(m_ptr) + k) % 4]) win = (int'(m_ptr) + k) % 4;
        end
        if (win >= 0) begin
          m_busy = 1'b1;
          m_gnt  = 4'b0000;
          m_gnt[win] = 1'b1;
          m_sel  = 2'(win);
          m_ptr  = 2'((win + 1) % 4);
          m_cnt  = 0;
        end else begin
          m_busy = 1'b0;
          m_gnt  = 4'b0000;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq, input logic dn);
    logic [7:0] e;
    @(negedge clk);
    reset = rst; req = rq; done = dn;
    model_step(rst, rq, dn);
    exp_q.push_back({m_gnt, m_sel, m_busy, m_to});
    @(posedge clk);
    #1;
    chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_gnt", 32'(gnt), 32'(e[7:4]));
      chk("sb_sel", 32'(sel), 32'(e[3:2]));
      chk("sb_busy", 32'(busy), 32'(e[1]));
      chk("sb_timeout", 32'(timeout), 32'(e[0]));
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [1:0] order[$];
    logic [1:0] exp_order[5];
    int held;
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // 1: reset with all requests, then grant to 0 one cycle after release
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    chk("t1_rst_gnt", 32'(gnt), 32'h0);
    chk("t1_rst_sel", 32'(sel), 32'h0);
    chk("t1_rst_busy", 32'(busy), 32'h0);
    step(1'b0, 4'b1111, 1'b0);
    chk("t1_first_gnt", 32'(gnt), 32'h1);

    // 2: done every 3rd cycle rotates 0,1,2,3,0 with no bubble
    order.push_back(sel);
    prev = gnt;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'b1111, (i % 3 == 2) ? 1'b1 : 1'b0);
      chk("t2_busy", 32'(busy), 32'h1);
      if (gnt != prev) order.push_back(sel);
      prev = gnt;
    end
    chk("t2_order_len", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) chk("t2_order", 32'(order[i]), 32'(exp_order[i]));
    end

    // 3: single requester 2, done, idle with sel held, re-grant
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    chk("t3_gnt", 32'(gnt), 32'h4);
    chk("t3_sel", 32'(sel), 32'h2);
    step(1'b0, 4'b0100, 1'b1);
    chk("t3_idle_gnt", 32'(gnt), 32'h0);
    chk("t3_idle_busy", 32'(busy), 32'h0);
    chk("t3_idle_sel", 32'(sel), 32'h2);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    chk("t3_hold_sel", 32'(sel), 32'h2);
    step(1'b0, 4'b0100, 1'b0);
    chk("t3_regrant", 32'(gnt), 32'h4);

    // 4: owner 1 withdraws while 3 waits
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    chk("t4_gnt1", 32'(gnt), 32'h2);
    step(1'b0, 4'b1010, 1'b0);
    chk("t4_nopreempt", 32'(gnt), 32'h2);
    step(1'b0, 4'b1000, 1'b0);
    chk("t4_gnt3", 32'(gnt), 32'h8);
    chk("t4_sel3", 32'(sel), 32'h3);
    chk("t4_no_timeout", 32'(timeout), 32'h0);

    // 5: timeout after exactly 16 held cycles, grant passes to 2
    step(1'b1, 4'b0000, 1'b0);
    held = 0;
    step(1'b0, 4'b0101, 1'b0);
    while (gnt == 4'b0001 && held < 40) begin
      held++;
      step(1'b0, 4'b0101, 1'b0);
    end
    chk("t5_held_cycles", 32'(held), 32'd16);
    chk("t5_timeout_pulse", 32'(timeout), 32'h1);
    chk("t5_next_gnt", 32'(gnt), 32'h4);
    step(1'b0, 4'b0101, 1'b0);
    chk("t5_pulse_1cyc", 32'(timeout), 32'h0);

    // 6: reset mid-grant clears grant and pointer
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    chk("t6_gnt3", 32'(gnt), 32'h8);
    step(1'b0, 4'b1000, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("t6_rst_gnt", 32'(gnt), 32'h0);
    chk("t6_rst_sel", 32'(sel), 32'h0);
    step(1'b0, 4'b1010, 1'b0);
    chk("t6_after_rst", 32'(gnt), 32'h2);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b1, 4'b0011, 1'b0);
    step(1'b0, 4'b0011, 1'b0);
    chk("t6_ptr_cleared", 32'(gnt), 32'h1);

    // random traffic, checked against the model through the scoreboard
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    // long holds to reach timeouts under contention
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 4'b1111, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
